// File: rtl/mix_columns_engine_pkg.sv
// Shared GF(2^8) helpers, coefficient rows and FSM state type for the
// MixColumns / InvMixColumns engine.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Row 0 of each circulant matrix; row i is this row rotated right by i bytes.
    localparam logic [31:0] FWD_ROW = {8'h02, 8'h03, 8'h01, 8'h01};
    localparam logic [31:0] INV_ROW = {8'h0e, 8'h0b, 8'h0d, 8'h09};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        return xtime(xtime(xtime(b)) ^ b) ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        return xtime(xtime(xtime(b) ^ b)) ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        return xtime(xtime(xtime(b) ^ b) ^ b);
    endfunction

    // Multiply by one of the seven coefficients that appear in either matrix.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        case (c)
            8'h01:   r = b;
            8'h02:   r = xtime(b);
            8'h03:   r = xtime(b) ^ b;
            8'h09:   r = gmul9(b);
            8'h0b:   r = gmul11(b);
            8'h0d:   r = gmul13(b);
            8'h0e:   r = gmul14(b);
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mix_columns_engine_if.sv
// Block-in / block-out handshake bundle of the mix-columns engine.
interface mix_columns_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/mix_columns_engine_unit.sv
// Combinational single-column mixer; inv selects the InvMixColumns matrix.
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [31:0] col,
    input  logic        inv,
    output logic [31:0] mixed
);

    logic [31:0] row_s;
    logic [7:0]  acc_s;

    // Output byte i = XOR over j of coef[(j - i) mod 4] * byte j.
    always_comb begin
        row_s = inv ? INV_ROW : FWD_ROW;
        mixed = 32'h0000_0000;
        acc_s = 8'h00;
        for (int i = 0; i < 4; i++) begin
            acc_s = 8'h00;
            for (int j = 0; j < 4; j++) begin
                acc_s = acc_s ^ gmul(col[31-8*j -: 8], row_s[31-8*((j-i+4)%4) -: 8]);
            end
            mixed[31-8*i -: 8] = acc_s;
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// Multi-cycle AES MixColumns / InvMixColumns engine mixing COLS_PER_CYCLE
// columns of a latched 128-bit state per clock, with a valid/ready result port.
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit REG_OUT        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    mix_columns_engine_if.slave  bus
);

    localparam int N  = 4 / COLS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_e        state_r;
    logic [CW-1:0] cnt_r;
    logic [127:0]  work_r;
    logic          inv_r;
    logic          out_valid_r;
    logic          busy_r;
    logic [127:0]  next_work_s;
    logic          last_s;
    logic [31:0]   col_in_s  [COLS_PER_CYCLE];
    logic [31:0]   col_out_s [COLS_PER_CYCLE];

    assign last_s       = (state_r == BUSY) && (cnt_r == LAST_CNT);
    assign bus.in_ready = (state_r == IDLE) || ((state_r == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

    // Pick the columns handled this cycle: unit k sees column cnt*C+k.
    always_comb begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_in_s[k] = work_r[32*(3 - (int'(cnt_r)*COLS_PER_CYCLE + k)) +: 32];
        end
    end

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_unit
        mix_column_unit u_mix (
            .col   (col_in_s[k]),
            .inv   (inv_r),
            .mixed (col_out_s[k])
        );
    end

    // Write the mixed columns back in place; untouched columns pass through.
    always_comb begin
        next_work_s = work_r;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            next_work_s[32*(3 - (int'(cnt_r)*COLS_PER_CYCLE + k)) +: 32] = col_out_s[k];
        end
    end

    // Control FSM and working register; mode is latched only at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            work_r      <= 128'h0;
            inv_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        work_r  <= bus.in_data;
                        inv_r   <= bus.in_inv;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    work_r <= next_work_s;
                    if (last_s) begin
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (bus.in_valid) begin
                            work_r  <= bus.in_data;
                            inv_r   <= bus.in_inv;
                            cnt_r   <= '0;
                            busy_r  <= 1'b1;
                            state_r <= BUSY;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= '0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    if (REG_OUT) begin : g_reg_out
        logic [127:0] out_r;

        // Capture the finished state on the last compute cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                out_r <= 128'h0;
            end else if (last_s) begin
                out_r <= next_work_s;
            end else begin
                out_r <= out_r;
            end
        end

        assign bus.out_data = out_r;
    end else begin : g_direct_out
        assign bus.out_data = work_r;
    end

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed self-checking bench; three engines (C=1,2,4) share the stimulus bus
// and each is driven by its own in_valid bit.
module tb_mix_columns_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid_v;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_ready;

    logic         in_ready_w  [3];
    logic         out_valid_w [3];
    logic         busy_w      [3];
    logic [127:0] out_data_w  [3];

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] FWD_EXP = 128'h8e4da1bc_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
    localparam logic [127:0] INV_EXP = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;

    always #5 clk = ~clk;

    mix_columns_engine_if if0 ();
    mix_columns_engine_if if1 ();
    mix_columns_engine_if if2 ();

    assign if0.in_valid = in_valid_v[0];
    assign if1.in_valid = in_valid_v[1];
    assign if2.in_valid = in_valid_v[2];
    assign if0.in_data = in_data;   assign if1.in_data = in_data;   assign if2.in_data = in_data;
    assign if0.in_inv = in_inv;     assign if1.in_inv = in_inv;     assign if2.in_inv = in_inv;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

    assign in_ready_w[0] = if0.in_ready;   assign in_ready_w[1] = if1.in_ready;   assign in_ready_w[2] = if2.in_ready;
    assign out_valid_w[0] = if0.out_valid; assign out_valid_w[1] = if1.out_valid; assign out_valid_w[2] = if2.out_valid;
    assign busy_w[0] = if0.busy;           assign busy_w[1] = if1.busy;           assign busy_w[2] = if2.busy;
    assign out_data_w[0] = if0.out_data;   assign out_data_w[1] = if1.out_data;   assign out_data_w[2] = if2.out_data;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .REG_OUT(1'b1)) u_c1 (.clk(clk), .rst(rst), .bus(if0));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .REG_OUT(1'b0)) u_c2 (.clk(clk), .rst(rst), .bus(if1));
    mix_columns_engine #(.COLS_PER_CYCLE(4), .REG_OUT(1'b1)) u_c4 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 2 : 1);
    endfunction

    // Shift-and-add GF(2^8) multiply, independent of the coefficient set.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s, input logic inv);
        logic [7:0]   fwd [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
        logic [7:0]   bwd [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        logic [7:0]   a   [4];
        logic [7:0]   r;
        logic [127:0] o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-32*c-8*j -: 8];
            for (int i = 0; i < 4; i++) begin
                r = 8'h00;
                for (int j = 0; j < 4; j++)
                    r = r ^ gf_mul(a[j], inv ? bwd[(j-i+4)%4] : fwd[(j-i+4)%4]);
                o[127-32*c-8*i -: 8] = r;
            end
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one block to engine sel, wait for its result and consume it.
    task automatic run_block(input int sel, input logic [127:0] d, input logic inv,
                             output logic [127:0] res, output int lat);
        int guard = 0;
        out_ready = 1'b1;
        while (!in_ready_w[sel] && guard < 20) begin
            step();
            guard++;
        end
        in_data = d;
        in_inv = inv;
        in_valid_v[sel] = 1'b1;
        step();
        in_valid_v[sel] = 1'b0;
        lat = 0;
        while (!out_valid_w[sel] && lat < 20) begin
            step();
            lat++;
        end
        res = out_data_w[sel];
        if (!out_valid_w[sel]) lat = -1;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid_v = 3'b000;
        in_data = 128'h0;
        in_inv = 1'b0;
        out_ready = 1'b1;
        step(); step(); step();
        for (int s = 0; s < 3; s++) begin
            checks++; if (in_ready_w[s] !== 1'b1) begin failures++; $display("FAIL reset_in_ready[%0d] got %b want 1", s, in_ready_w[s]); end
            checks++; if (out_valid_w[s] !== 1'b0) begin failures++; $display("FAIL reset_out_valid[%0d] got %b want 0", s, out_valid_w[s]); end
            checks++; if (busy_w[s] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got %b want 0", s, busy_w[s]); end
            checks++; if (out_data_w[s] !== 128'h0) begin failures++; $display("FAIL reset_out_data[%0d] got %h want 0", s, out_data_w[s]); end
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_vectors();
        logic [127:0] res;
        int lat;
        for (int s = 0; s < 3; s++) begin
            run_block(s, FWD_IN, 1'b0, res, lat);
            checks++; if (res !== FWD_EXP) begin failures++; $display("FAIL fwd_data[%0d] got %h want %h", s, res, FWD_EXP); end
            checks++; if (lat !== lat_of(s)) begin failures++; $display("FAIL fwd_latency[%0d] got %0d want %0d", s, lat, lat_of(s)); end
            run_block(s, INV_IN, 1'b1, res, lat);
            checks++; if (res !== INV_EXP) begin failures++; $display("FAIL inv_data[%0d] got %h want %h", s, res, INV_EXP); end
            checks++; if (lat !== lat_of(s)) begin failures++; $display("FAIL inv_latency[%0d] got %0d want %0d", s, lat, lat_of(s)); end
        end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig, fwd, back, exp;
        int lat;
        for (int it = 0; it < 1000; it++) begin
            orig = {$urandom, $urandom, $urandom, $urandom};
            exp = model_mix(orig, 1'b0);
            for (int s = 0; s < 3; s++) begin
                run_block(s, orig, 1'b0, fwd, lat);
                checks++; if (fwd !== exp) begin failures++; $display("FAIL rt_fwd[%0d] got %h want %h", s, fwd, exp); end
                run_block(s, fwd, 1'b1, back, lat);
                checks++; if (back !== orig) begin failures++; $display("FAIL rt_inv[%0d] got %h want %h", s, back, orig); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [3];
        logic [127:0] exp [3];
        int acc_cyc [3] = '{0, 0, 0};
        int idx = 0;
        int outs = 0;
        bit toggled = 1'b0;
        bit acc;
        blk[0] = FWD_IN;
        blk[1] = 128'h01234567_89abcdef_fedcba98_76543210;
        blk[2] = 128'hf20a225c_d4d4d4d5_00000000_ffffffff;
        for (int i = 0; i < 3; i++) exp[i] = model_mix(blk[i], 1'b0);
        in_inv = 1'b0;
        out_ready = 1'b1;
        in_data = blk[0];
        in_valid_v[0] = 1'b1;
        for (int cyc = 0; cyc < 40 && outs < 3; cyc++) begin
            if (out_valid_w[0]) begin
                checks++; if (out_data_w[0] !== exp[outs]) begin failures++; $display("FAIL b2b_data[%0d] got %h want %h", outs, out_data_w[0], exp[outs]); end
                checks++; if (in_ready_w[0] !== 1'b1) begin failures++; $display("FAIL b2b_ready_done got %b want 1", in_ready_w[0]); end
                if (!toggled) begin
                    out_ready = 1'b0;
                    #1;
                    checks++; if (in_ready_w[0] !== 1'b0) begin failures++; $display("FAIL b2b_ready_comb got %b want 0", in_ready_w[0]); end
                    out_ready = 1'b1;
                    #1;
                    toggled = 1'b1;
                end
                outs++;
            end
            acc = in_valid_v[0] && in_ready_w[0];
            if (acc) acc_cyc[idx] = cyc;
            step();
            if (acc) begin
                idx++;
                if (idx < 3) in_data = blk[idx];
                else in_valid_v[0] = 1'b0;
            end
        end
        in_valid_v[0] = 1'b0;
        checks++; if (outs !== 3) begin failures++; $display("FAIL b2b_count got %0d want 3", outs); end
        checks++; if (acc_cyc[1] - acc_cyc[0] !== 5) begin failures++; $display("FAIL b2b_spacing_ab got %0d want 5", acc_cyc[1] - acc_cyc[0]); end
        checks++; if (acc_cyc[2] - acc_cyc[1] !== 5) begin failures++; $display("FAIL b2b_spacing_bc got %0d want 5", acc_cyc[2] - acc_cyc[1]); end
        step();
    endtask

    task automatic test_stall_mode();
        int lat = 0;
        int bad = 0;
        out_ready = 1'b0;
        in_data = INV_IN;
        in_inv = 1'b1;
        in_valid_v[0] = 1'b1;
        step();
        checks++; if (busy_w[0] !== 1'b1) begin failures++; $display("FAIL stall_busy got %b want 1", busy_w[0]); end
        checks++; if (in_ready_w[0] !== 1'b0) begin failures++; $display("FAIL stall_ready_busy got %b want 0", in_ready_w[0]); end
        while (!out_valid_w[0] && lat < 20) begin
            in_inv = ~in_inv;
            in_data = ~in_data;
            step();
            lat++;
        end
        checks++; if (lat !== 4) begin failures++; $display("FAIL stall_latency got %0d want 4", lat); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid_w[0] !== 1'b1 || out_data_w[0] !== INV_EXP || in_ready_w[0] !== 1'b0) bad++;
            in_inv = ~in_inv;
            step();
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
        checks++; if (out_data_w[0] !== INV_EXP) begin failures++; $display("FAIL stall_data got %h want %h", out_data_w[0], INV_EXP); end
        in_valid_v[0] = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (out_valid_w[0] !== 1'b0) begin failures++; $display("FAIL stall_release_valid got %b want 0", out_valid_w[0]); end
        checks++; if (in_ready_w[0] !== 1'b1) begin failures++; $display("FAIL stall_release_ready got %b want 1", in_ready_w[0]); end
    endtask

    task automatic test_reset_busy();
        logic [127:0] res;
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        in_data = FWD_IN;
        in_inv = 1'b0;
        in_valid_v[0] = 1'b1;
        step();
        in_valid_v[0] = 1'b0;
        step();
        rst = 1'b1;
        in_valid_v[0] = 1'b1;
        step();
        rst = 1'b0;
        in_valid_v[0] = 1'b0;
        checks++; if (busy_w[0] !== 1'b0) begin failures++; $display("FAIL rstbusy_busy got %b want 0", busy_w[0]); end
        checks++; if (out_valid_w[0] !== 1'b0) begin failures++; $display("FAIL rstbusy_valid got %b want 0", out_valid_w[0]); end
        checks++; if (out_data_w[0] !== 128'h0) begin failures++; $display("FAIL rstbusy_data got %h want 0", out_data_w[0]); end
        checks++; if (in_ready_w[0] !== 1'b1) begin failures++; $display("FAIL rstbusy_ready got %b want 1", in_ready_w[0]); end
        for (int i = 0; i < 6; i++) begin
            if (out_valid_w[0] !== 1'b0) seen++;
            step();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL rstbusy_no_output got %0d valid cycles want 0", seen); end
        run_block(0, INV_IN, 1'b1, res, lat);
        checks++; if (res !== INV_EXP) begin failures++; $display("FAIL rstbusy_fresh_data got %h want %h", res, INV_EXP); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL rstbusy_fresh_latency got %0d want 4", lat); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_stall_mode();
        test_reset_busy();
        test_round_trip();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
Name: mix_columns_engine

Overview:
- Multi-cycle AES MixColumns / InvMixColumns engine for the AES datapath.
- Takes a 128-bit state and a per-block mode bit (forward or inverse), and processes COLS_PER_CYCLE 32-bit columns per clock.
- Returns the result over a valid/ready handshake.
- Replaces separate fixed-direction combinational column mixers, so one engine serves both the encrypt and decrypt round pipelines.

Parameters:
- COLS_PER_CYCLE, 1, columns mixed per clock; legal values 1, 2, 4. N = 4/COLS_PER_CYCLE compute cycles per block.
- REG_OUT, 1, 1 = out_data driven from a register; 0 = out_data is the working register (same timing, fewer flops). Both settings must produce identical cycle behaviour.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input block present.
- in_ready  output  1  engine can accept a block this cycle.
- in_data  input  128  state; column 0 = [127:96], column 3 = [31:0]; byte 0 of each column is its MSB.
- in_inv  input  1  0 = MixColumns (02 03 01 01); 1 = InvMixColumns (0e 0b 0d 09).
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_data  output  128  mixed state, same column/byte layout as in_data.
- busy  output  1  high in BUSY state.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0, state=IDLE, column counter=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch in_data and in_inv, clear the column counter, go to BUSY.
  - BUSY: in_ready=0, busy=1. Each cycle, mix columns [cnt*C .. cnt*C+C-1] of the working register in place; cnt += 1. After the cycle with cnt = N-1, go to DONE.
  - DONE: out_valid=1, out_data stable. out_ready with no in_valid: go to IDLE. out_ready and in_valid together: accept the new block in the same cycle and go to BUSY.
- in_ready = (state==IDLE) | (state==DONE & out_ready). in_ready combinationally depends on out_ready; this is the only combinational path.
- Latency:
  - out_valid rises N cycles after the accepting edge (C=1: 4; C=2: 2; C=4: 1).
  - Sustained throughput is one block per N+1 cycles with out_ready held high.
- Mode is sampled only at accept. Changes to in_inv during BUSY have no effect.
- in_data is ignored whenever in_ready=0. No input buffering.
- Output stall: while out_valid=1 and out_ready=0, out_data is held bit-stable and in_ready=0.
- GF(2^8) arithmetic:
  - xtime(b) = {b[6:0],0} ^ (8'h1b & {8{b[7]}}).
  - Products by 09, 0b, 0d, 0e are built from xtime chains. All results are exactly 8 bits.
- Reset asserted in any state: next cycle is IDLE with reset values. An in-flight block is discarded with no partial output. Reset dominates in_valid in the same cycle.
- Column counter width is clog2(N) (minimum 1 bit). It never wraps past N-1.

Decomposition:
- Package aes_pkg:
  - function xtime;
  - functions gmul9, gmul11, gmul13, gmul14;
  - constants for the forward and inverse coefficient rows;
  - state enum typedef {IDLE, BUSY, DONE}.
- Sub-module mix_column_unit:
  - combinational; 32-bit column in, inv select, 32-bit column out.
  - Instantiated COLS_PER_CYCLE times.
  - Instance k operates on column cnt*C+k, selected by mux from the working register.

Test Plan:
- Forward, C=1: in_data column 0 = db135345, other columns c6c6c6c6, in_inv=0 → after 4 cycles out_valid=1, out_data = 8e4da1bc_c6c6c6c6_c6c6c6c6_c6c6c6c6.
- Inverse, all C values: in_data = 8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6, in_inv=1 → out_data = db135345_f20a225c_c6c6c6c6_d4d4d4d5. Latency must be 4, 2 and 1 cycles respectively.
- Round trip: 1000 random states, forward then inverse through the same engine → output equals the original. Compare against a software model for every C.
- Back-to-back: out_ready tied high, in_valid high, blocks A, B, C → accepts every N+1 cycles and results emerge in order. Assert in_ready combinationally in DONE.
- Stall plus mode glitch: hold out_ready=0 for 10 cycles and toggle in_inv during BUSY → out_data stable, in_ready=0, result matches the mode latched at accept.
- Reset in BUSY: assert rst on cycle 2 of a C=1 block → next cycle state IDLE, out_valid=0, out_data=0. A fresh block then completes correctly.
